// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes reset release, holds selected channels, then releases them staggered.
// Optional run-time timeout flag enabled by defining RST_SEQ_TIMEOUT_EN.
module rst_seq_ctrl #(
  parameter int          NUM_CH      = 2,
  parameter int          HOLD_CYC    = 10,
  parameter int          STAGGER_CYC = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000
) (
  input  logic              SYS_FCLK,
  input  logic              SYS_RESET,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] ch_resetn,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              timeout
);

  localparam int MAX_CYC = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  STAG_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);

  localparam logic [1:0] S_SYNC    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  logic              r_sync;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_sel;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_rstn;
  logic              r_busy;
  logic              r_done;

  logic [NUM_CH-1:0] w_first;
  logic [NUM_CH-1:0] w_first_rem;
  logic [NUM_CH-1:0] w_next;
  logic [NUM_CH-1:0] w_next_rem;
  logic              w_req_ok;

  function automatic logic [NUM_CH-1:0] lowest_bit(input logic [NUM_CH-1:0] v);
    return v & (~v + CH_ONE);
  endfunction

  assign w_first     = lowest_bit(r_sel);
  assign w_first_rem = r_sel & ~w_first;
  assign w_next      = lowest_bit(r_pend);
  assign w_next_rem  = r_pend & ~w_next;
  assign w_req_ok    = (r_state == S_RUN) && sw_rst_req && (ch_mask != '0);

  // r_sync is the first synchronizer stage; the SYNC state register acts as the second.
  always_ff @(posedge SYS_FCLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      r_sync  <= 1'b0;
      r_state <= S_SYNC;
      r_cnt   <= '0;
      r_sel   <= '1;
      r_pend  <= '0;
      r_rstn  <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_sync <= 1'b1;
      r_done <= 1'b0;
      case (r_state)
        S_SYNC: begin
          if (r_sync) begin
            r_state <= S_ASSERT;
            r_cnt   <= '0;
            r_rstn  <= r_rstn & ~r_sel;
          end
        end
        S_ASSERT: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt  <= '0;
            r_rstn <= r_rstn | w_first;
            r_pend <= w_first_rem;
            if (w_first_rem == '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RELEASE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_RELEASE: begin
          if (r_cnt == STAG_LAST) begin
            r_cnt  <= '0;
            r_rstn <= r_rstn | w_next;
            r_pend <= w_next_rem;
            if (w_next_rem == '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          // Mask is latched here so later ch_mask changes cannot alter a running sequence.
          if (w_req_ok) begin
            r_sel   <= ch_mask;
            r_rstn  <= r_rstn & ~ch_mask;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_ASSERT;
          end
        end
      endcase
    end
  end

  assign ch_resetn = r_rstn;
  assign seq_busy  = r_busy;
  assign seq_done  = r_done;

`ifdef RST_SEQ_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_timeout;

  always_ff @(posedge SYS_FCLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_RUN && !w_req_ok) begin
      if (r_to_cnt != TIMEOUT_CYC) begin
        r_to_cnt <= r_to_cnt + 32'd1;
        if (r_to_cnt == TIMEOUT_CYC - 32'd1) r_timeout <= 1'b1;
      end else begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_to_cnt <= '0;
      if (w_req_ok) r_timeout <= 1'b0;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: default 2-channel instance plus a 4-channel, stagger-1 instance.
module tb_rst_seq_ctrl;

  typedef struct {
    logic       req;
    logic [1:0] mask;
    logic [1:0] rstn;
    logic       busy;
    logic       done;
    logic [3:0] rstn4;
    logic       done4;
  } vec_t;

  logic       clk = 1'b0;
  logic       SYS_RESET = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [1:0] ch_mask = 2'b00;
  logic [1:0] ch_resetn;
  logic       seq_busy, seq_done, timeout;
  logic [3:0] ch_resetn4;
  logic       seq_busy4, seq_done4, timeout4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic exp_to;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  rst_seq_ctrl #(.NUM_CH(2), .HOLD_CYC(10), .STAGGER_CYC(4), .TIMEOUT_CYC(32'd100)) dut (
    .SYS_FCLK(clk), .SYS_RESET(SYS_RESET), .sw_rst_req(sw_rst_req), .ch_mask(ch_mask),
    .ch_resetn(ch_resetn), .seq_busy(seq_busy), .seq_done(seq_done), .timeout(timeout)
  );

  rst_seq_ctrl #(.NUM_CH(4), .HOLD_CYC(10), .STAGGER_CYC(1)) dut4 (
    .SYS_FCLK(clk), .SYS_RESET(SYS_RESET), .sw_rst_req(1'b0), .ch_mask(4'b0000),
    .ch_resetn(ch_resetn4), .seq_busy(seq_busy4), .seq_done(seq_done4), .timeout(timeout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_vec(input logic req, input logic [1:0] mask, input logic [1:0] rstn,
                         input logic busy, input logic done, input logic [3:0] rstn4,
                         input logic done4, input int n);
    vec_t v;
    v.req = req; v.mask = mask; v.rstn = rstn; v.busy = busy; v.done = done;
    v.rstn4 = rstn4; v.done4 = done4;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    vec_t e;
    for (int i = lo; i <= hi; i++) begin
      sw_rst_req = tbl[i].req;
      ch_mask    = tbl[i].mask;
      sb.push_back(tbl[i]);
      tick();
      e = sb.pop_front();
      chk("ch_resetn", 32'(ch_resetn), 32'(e.rstn));
      chk("seq_busy", 32'(seq_busy), 32'(e.busy));
      chk("seq_done", 32'(seq_done), 32'(e.done));
      chk("ch_resetn4", 32'(ch_resetn4), 32'(e.rstn4));
      chk("seq_done4", 32'(seq_done4), 32'(e.done4));
    end
    sw_rst_req = 1'b0;
    ch_mask    = 2'b00;
  endtask

  task automatic chk_reset_state();
    chk("rst ch_resetn", 32'(ch_resetn), 32'h0);
    chk("rst seq_busy", 32'(seq_busy), 32'h1);
    chk("rst seq_done", 32'(seq_done), 32'h0);
    chk("rst timeout", 32'(timeout), 32'h0);
    chk("rst ch_resetn4", 32'(ch_resetn4), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef RST_SEQ_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    // Power-up sequence, cycles 1..16 (indices 0..15); request at cycle 5 must be ignored.
    add_vec(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0, 4);
    add_vec(1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0, 1);
    add_vec(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0, 6);
    add_vec(1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 4'b0001, 1'b0, 1);
    add_vec(1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 4'b0011, 1'b0, 1);
    add_vec(1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 4'b0111, 1'b0, 1);
    add_vec(1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 4'b1111, 1'b1, 1);
    add_vec(1'b0, 2'b00, 2'b11, 1'b0, 1'b1, 4'b1111, 1'b0, 1);
    // RUN-phase requests, cycles 17..35 (indices 16..34).
    add_vec(1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b0, 1);
    add_vec(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b0, 1);
    add_vec(1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b0, 2);
    add_vec(1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 4'b1111, 1'b0, 1);
    add_vec(1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 4'b1111, 1'b0, 3);
    add_vec(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 4'b1111, 1'b0, 1);
    add_vec(1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 4'b1111, 1'b0, 5);
    add_vec(1'b0, 2'b00, 2'b11, 1'b0, 1'b1, 4'b1111, 1'b0, 1);
    add_vec(1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b0, 4);

    #1 SYS_RESET = 1'b1;
    #1;
    chk_reset_state();
    repeat (10) tick();
    chk_reset_state();
    SYS_RESET = 1'b0;
    cyc = 0;
    run_vecs(0, 34);

    // Timeout: RUN entered at cycle 31, flag expected at cycle 131.
    while (cyc < 130) tick();
    chk("timeout before limit", 32'(timeout), 32'h0);
    tick();
    chk("timeout at limit", 32'(timeout), 32'(exp_to));
    tick();
    chk("timeout sticky", 32'(timeout), 32'(exp_to));
    sw_rst_req = 1'b1;
    ch_mask    = 2'b01;
    tick();
    sw_rst_req = 1'b0;
    ch_mask    = 2'b00;
    chk("timeout cleared", 32'(timeout), 32'h0);
    chk("sw ch_resetn", 32'(ch_resetn), 32'h2);
    chk("sw seq_busy", 32'(seq_busy), 32'h1);
    repeat (9) tick();
    chk("hold ch_resetn", 32'(ch_resetn), 32'h2);
    tick();
    chk("done ch_resetn", 32'(ch_resetn), 32'h3);
    chk("done seq_done", 32'(seq_done), 32'h1);
    chk("done seq_busy", 32'(seq_busy), 32'h0);

    // Full restart, then reset pulse at cycle 14 mid-release.
    SYS_RESET = 1'b1;
    repeat (3) tick();
    SYS_RESET = 1'b0;
    cyc = 0;
    run_vecs(0, 13);
    #3;
    SYS_RESET = 1'b1;
    #1;
    chk("async ch_resetn", 32'(ch_resetn), 32'h0);
    chk("async seq_busy", 32'(seq_busy), 32'h1);
    chk("async ch_resetn4", 32'(ch_resetn4), 32'h0);
    repeat (2) tick();
    chk_reset_state();
    SYS_RESET = 1'b0;
    cyc = 0;
    run_vecs(0, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port SHALL be SYS_FCLK and the reset port SHALL be SYS_RESET.
REQ-002 Parameter NUM_CH, default 2: number of sequenced reset channels, range 1..16.
REQ-003 Parameter HOLD_CYC, default 10: SYS_FCLK cycles all selected channels are held in reset, minimum 1.
REQ-004 Parameter STAGGER_CYC, default 4: cycles between successive channel releases, minimum 1.
REQ-005 Parameter TIMEOUT_CYC, default 2_000_000: cycles in RUN before timeout asserts, 32-bit.
REQ-006 Port SYS_FCLK  input  1: system clock; all state changes on its rising edge.
REQ-007 Port SYS_RESET  input  1: asynchronous active-high reset.
REQ-008 Port sw_rst_req  input  1: single-cycle request to re-run the sequence on masked channels.
REQ-009 Port ch_mask  input  NUM_CH: channels affected by sw_rst_req, 1 = included.
REQ-010 Port ch_resetn  output  NUM_CH: per-channel active-low reset to subsystems.
REQ-011 Port seq_busy  output  1: high while a sequence is in progress.
REQ-012 Port seq_done  output  1: one-cycle pulse when a sequence completes.
REQ-013 Port timeout  output  1: sticky run-time limit flag.

Function
REQ-014 "Cycle N" SHALL denote register values after the Nth SYS_FCLK rising edge following SYS_RESET deassertion.
REQ-015 SYS_RESET deassertion SHALL pass through a 2-flop synchronizer, so the FSM leaves SYNC and enters ASSERT at cycle 2.
REQ-016 FSM states SHALL be SYNC, ASSERT, RELEASE and RUN; SYNC is entered only via SYS_RESET.
REQ-017 ASSERT SHALL hold every selected channel low for HOLD_CYC cycles and then enter RELEASE.
REQ-018 RELEASE SHALL raise selected channels in ascending index order, one channel per STAGGER_CYC cycles; the lowest selected channel rises on RELEASE entry.
REQ-019 With defaults, ch_resetn[0] SHALL rise at cycle 12 and ch_resetn[1] at cycle 16.
REQ-020 The last selected release SHALL enter RUN in the same cycle, pulse seq_done for exactly one cycle and drop seq_busy in that cycle.
REQ-021 Unselected channels SHALL keep their current value throughout a sequence; after SYS_RESET all channels are selected.
REQ-022 In RUN, sw_rst_req with ch_mask != 0 SHALL, on the next cycle, drive the masked channels low, set seq_busy and enter ASSERT.
REQ-023 The mask SHALL be captured when the request is accepted.
REQ-024 sw_rst_req with ch_mask == 0 SHALL be ignored.
REQ-025 sw_rst_req during SYNC, ASSERT or RELEASE SHALL be ignored and SHALL NOT be queued.
REQ-026 Hold and stagger counters SHALL be sized as clog2 of the larger of HOLD_CYC and STAGGER_CYC, plus 1, and SHALL NOT wrap.

Reset
REQ-027 While SYS_RESET is high, asynchronously: ch_resetn = all 0, seq_busy = 1, seq_done = 0, timeout = 0, FSM = SYNC, all counters 0.
REQ-028 SYS_RESET asserted mid-sequence or in RUN SHALL abort immediately and restart from SYNC after deassertion, with all channels selected.

Configuration
REQ-029 Macro RST_SEQ_TIMEOUT_EN SHALL gate the timeout feature.
REQ-030 When RST_SEQ_TIMEOUT_EN is defined, a 32-bit counter SHALL count cycles spent in RUN and clear on leaving RUN.
REQ-031 When RST_SEQ_TIMEOUT_EN is defined, timeout SHALL be set when the counter reaches TIMEOUT_CYC, stay set until SYS_RESET or an accepted sw_rst_req, and the counter SHALL saturate.
REQ-032 When RST_SEQ_TIMEOUT_EN is not defined, timeout SHALL be tied to 0 and no counter shall be synthesised.

Verification
REQ-033 Defaults, SYS_RESET high 10 cycles then low -> ch_resetn 00 through cycle 11, 01 at cycle 12, 11 at cycle 16; seq_done high only in cycle 16.
REQ-034 In RUN, sw_rst_req=1 with ch_mask=10 -> ch_resetn=01 on the next cycle, seq_busy=1, ch_resetn=11 after HOLD_CYC cycles, single seq_done pulse.
REQ-035 sw_rst_req at cycle 5, and in RUN with ch_mask=00 -> no change to ch_resetn, seq_busy or seq_done.
REQ-036 SYS_RESET pulsed at cycle 14 -> ch_resetn=00 immediately without a clock edge; the full default sequence repeats after release.
REQ-037 RST_SEQ_TIMEOUT_EN defined, TIMEOUT_CYC=100 -> timeout rises 100 cycles after RUN entry and clears on an accepted sw_rst_req; with the macro undefined, timeout stays 0.
REQ-038 NUM_CH=4, STAGGER_CYC=1 -> the channels release on consecutive cycles 12, 13, 14, 15.
